// File: rtl/aes256_key_expansion_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_key_expansion_pkg
//  Description : Shared types and constants for the AES-256 key schedule.
//                Provides the round key bundle type, the FSM state encoding,
//                the round constant table and the forward S-box table.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes256_key_expansion_pkg;

  localparam int AES_ROUND_NUMBER = 14;
  localparam int AES_KEY_WIDTH    = 256;

  // Round key k sits at index k; within a key, w[4k] occupies [127:96].
  typedef logic [AES_ROUND_NUMBER:0][127:0] round_keys_t;

  typedef enum logic [1:0] {
    KX_IDLE   = 2'd0,
    KX_EXPAND = 2'd1,
    KX_DONE   = 2'd2
  } kx_state_t;

  // Indexed by i/8 during expansion; entry 0 is never selected.
  localparam logic [7:0] AES_RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage
`default_nettype wire

// File: rtl/aes256_key_expansion_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_key_expansion_sbox
//  Description : Forward AES S-box, purely combinational table lookup.
//  Ports       : in_byte  - byte to substitute
//                out_byte - substituted byte
//  Revision    : 1.0 - initial release
// ============================================================================
module aes256_key_expansion_sbox
  import aes256_key_expansion_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = AES_SBOX[in_byte];

endmodule
`default_nettype wire

// File: rtl/aes256_key_expansion.sv
`default_nettype none
// ============================================================================
//  Module      : aes256_key_expansion
//  Description : Iterative AES-256 key schedule. Accepts a 256-bit key on a
//                valid/ready handshake, computes one schedule word per cycle
//                (words 8..59) and then holds all 15 round keys stable with
//                round_keys_valid high until the next key is accepted.
//  Ports       : clk              - clock, rising edge
//                resetn           - asynchronous active-low reset
//                key_in_tdata     - cipher key, [255:224] = w[0]
//                key_in_tvalid    - key present
//                key_in_tready    - key accepted when tvalid & tready
//                cipher_idle      - downstream round pipelines are empty
//                round_keys       - 15 round keys, key k = {w[4k]..w[4k+3]}
//                round_keys_valid - schedule complete and stable
//  Revision    : 1.0 - initial release
// ============================================================================
module aes256_key_expansion
  import aes256_key_expansion_pkg::*;
#(
  parameter int ROUND_NUMBER = AES_ROUND_NUMBER,
  parameter int KEY_WIDTH    = AES_KEY_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [KEY_WIDTH-1:0] key_in_tdata,
  input  logic                 key_in_tvalid,
  output logic                 key_in_tready,
  input  logic                 cipher_idle,
  output round_keys_t          round_keys,
  output logic                 round_keys_valid
);

  localparam int         NUM_WORDS = 4 * (ROUND_NUMBER + 1);
  localparam int         KEY_WORDS = KEY_WIDTH / 32;
  localparam logic [5:0] LAST_WORD = 6'(NUM_WORDS - 1);

  kx_state_t                   state;
  kx_state_t                   state_next;
  logic [NUM_WORDS-1:0][31:0]  words;
  logic [5:0]                  idx;
  logic                        accept;

  logic [31:0] prev_word;
  logic [31:0] back_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [7:0]  rcon;
  logic [31:0] new_word;

  // resetn gates ready so no key can appear accepted while reset is held.
  assign key_in_tready = (state != KX_EXPAND) & cipher_idle & resetn;
  assign accept        = key_in_tvalid & key_in_tready;

  // ---------------------------------------------------------------------------
  // Word generator: w[i-1] and w[i-8] come straight from the schedule storage.
  // ---------------------------------------------------------------------------
  assign prev_word = words[idx - 6'd1];
  assign back_word = words[idx - 6'd8];

  // RotWord only applies on the i%8==0 step; the i%8==4 step substitutes w[i-1] as is.
  assign sub_in = (idx[2:0] == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
  assign rcon   = AES_RCON[idx[5:3]];

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes256_key_expansion_sbox u_sbox (
      .in_byte  (sub_in[8*b +: 8]),
      .out_byte (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    new_word = back_word ^ prev_word;
    case (idx[2:0])
      3'd0:    new_word = back_word ^ sub_out ^ {rcon, 24'h0};
      3'd4:    new_word = back_word ^ sub_out;
      default: new_word = back_word ^ prev_word;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= KX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      KX_IDLE:   if (accept) state_next = KX_EXPAND;
      KX_EXPAND: if (idx == LAST_WORD) state_next = KX_DONE;
      KX_DONE:   if (accept) state_next = KX_EXPAND;
      default:   state_next = KX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Schedule storage, word counter and valid flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      words            <= '0;
      idx              <= '0;
      round_keys_valid <= 1'b0;
    end else if (accept) begin
      for (int j = 0; j < KEY_WORDS; j++) begin
        words[j] <= key_in_tdata[KEY_WIDTH-1-32*j -: 32];
      end
      idx              <= 6'(KEY_WORDS);
      round_keys_valid <= 1'b0;
    end else if (state == KX_EXPAND) begin
      words[idx] <= new_word;
      idx        <= idx + 6'd1;
      if (idx == LAST_WORD) begin
        round_keys_valid <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k <= ROUND_NUMBER; k++) begin : g_round_key
    assign round_keys[k] = {words[4*k], words[4*k+1], words[4*k+2], words[4*k+3]};
  end

endmodule
`default_nettype wire
